// File: rtl/kypd_pkg.sv
// ------------------------------------------------------------------
// kypd_pkg : state encoding and key-map helpers for the keypad emulator
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package kypd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [3:0] ALL_RELEASED = 4'hF;

  // Row index (0 = Row1) of a hex key on the Pmod KYPD layout.
  function automatic logic [1:0] key_row(input logic [3:0] code);
    case (code)
      4'h1, 4'h2, 4'h3, 4'hA: key_row = 2'd0;
      4'h4, 4'h5, 4'h6, 4'hB: key_row = 2'd1;
      4'h7, 4'h8, 4'h9, 4'hC: key_row = 2'd2;
      default:                key_row = 2'd3;
    endcase
  endfunction

  // Column index (0 = Col1) of a hex key on the Pmod KYPD layout.
  function automatic logic [1:0] key_col(input logic [3:0] code);
    case (code)
      4'h1, 4'h4, 4'h7, 4'h0: key_col = 2'd0;
      4'h2, 4'h5, 4'h8, 4'hF: key_col = 2'd1;
      4'h3, 4'h6, 4'h9, 4'hE: key_col = 2'd2;
      default:                key_col = 2'd3;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/kypd_key_fifo.sv
// ------------------------------------------------------------------
// kypd_key_fifo : DEPTH-entry queue of 4-bit key codes with flush
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module kypd_key_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  logic [3:0] din,
  input  logic       pop,
  output logic [3:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/kypd_key_emulator.sv
// ------------------------------------------------------------------
// kypd_key_emulator : plays queued hex keys back onto a KYPD scan bus
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module kypd_key_emulator
  import kypd_pkg::*;
#(
  parameter int HOLD_CYCLES = 2_000_000,
  parameter int GAP_CYCLES  = 2_000_000,
  parameter int DEPTH       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_in,
  input  logic       key_in_valid,
  output logic       key_in_ready,
  input  logic       abort,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic       pressed,
  output logic [3:0] cur_key,
  output logic       busy
);

  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

  state_t        state;
  logic [CW-1:0] counter;
  logic [3:0]    head;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign key_in_ready = !full;
  assign push         = key_in_valid && !full;
  assign pop          = (state == ST_IDLE) && !empty && !abort;

  kypd_key_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (abort),
    .push  (push),
    .din   (key_in),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      counter <= '0;
      pressed <= 1'b0;
      cur_key <= 4'h0;
      busy    <= 1'b0;
      row     <= ALL_RELEASED;
    end else if (abort) begin
      // cur_key deliberately survives an abort so software can see what was cut short
      state   <= ST_IDLE;
      counter <= '0;
      pressed <= 1'b0;
      busy    <= 1'b0;
      row     <= ALL_RELEASED;
    end else begin
      busy <= (state != ST_IDLE) || !empty;
      row  <= (pressed && !col[key_col(cur_key)]) ? ~(4'b0001 << key_row(cur_key))
                                                  : ALL_RELEASED;
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            cur_key <= head;
            counter <= '0;
            pressed <= 1'b1;
            state   <= ST_PRESS;
          end
        end
        ST_PRESS: begin
          if (counter == HOLD_LAST) begin
            counter <= '0;
            pressed <= 1'b0;
            state   <= ST_GAP;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        ST_GAP: begin
          if (counter == GAP_LAST) begin
            counter <= '0;
            state   <= ST_IDLE;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        default: begin
          counter <= '0;
          pressed <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
